reg_wb_scheduler: RTL and testbench
===================================

# reg_wb_scheduler

Write-back scheduler for the 32-entry register file's single synchronous write port. It arbitrates round-robin among several result producers (pipeline ALU path, multiply/divide unit, load/store unit) and registers the winning write onto the register-file write port. It discards writes to x0, so the register file never sees a write enable for x0. It also keeps a per-register busy scoreboard (set on issue, cleared on committed write) that the decode stage queries for RAW hazards.

## Interface
Parameters:
- NUM_REQ, 3, number of write-back requesters; index 0 = pipeline, 1 = mul/div, 2 = LSU; legal range 2..8.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester write request.
- req_addr_i  input  NUM_REQ x reg_addr_t  destination register per requester.
- req_data_i  input  NUM_REQ x word_t  write data per requester.
- req_ready_o  output  NUM_REQ  grant; the transfer occurs when valid&ready.
- rf_write_en_o  output  1  register-file write enable.
- rf_rd_addr_o  output  reg_addr_t  register-file write address.
- rf_rd_data_o  output  word_t  register-file write data.
- issue_valid_i  input  1  decode issues an instruction that will write issue_rd_i.
- issue_rd_i  input  reg_addr_t  destination of the issued instruction.
- rs1_addr_i, rs2_addr_i  input  reg_addr_t  hazard query addresses.
- rs1_busy_o, rs2_busy_o  output  1  the queried register has a pending write.

## Operation
- Arbitration:
  - The scheduler grants at most one requester per cycle, round-robin.
  - A priority pointer ptr (0..NUM_REQ-1) marks the highest-priority index. The winner is the first valid index scanning ptr, ptr+1, … modulo NUM_REQ.
  - req_ready_o is one-hot for the winner and all-zero when no request is valid. It is combinational from req_valid_i and ptr.
  - After a grant to index k, ptr becomes (k+1) mod NUM_REQ. With no grant, ptr holds.
- Requester rules:
  - Once asserted, valid is held with stable addr/data until ready.
  - Requesters must not derive valid from ready.
- Output stage:
  - The output stage is a single register. It never stalls, because the register file always accepts a write.
  - Accepted transfer with addr≠0: rf_write_en_o=1, addr and data registered.
  - Accepted transfer with addr=0: the handshake completes normally, but rf_write_en_o=0.
  - No transfer: rf_write_en_o=0. Address and data hold their last values.
- Scoreboard:
  - busy is a REG_COUNT-bit vector, and busy[0] is constant 0.
  - On issue_valid_i with issue_rd_i≠0, busy[issue_rd_i] is set.
  - On rf_write_en_o=1, busy[rf_rd_addr_o] is cleared at the same edge the register file commits the write.
  - Set and clear of the same register in the same cycle: set wins, because the new producer's result is still pending.
  - rsN_busy_o = busy[rsN_addr_i], combinational. Address 0 always returns 0.
  - Issue to a register that is already busy is illegal; decode stalls until it clears.

## Timing
- Reset values: all outputs 0, ptr=0, busy all zero. Reset mid-operation drops any registered write and clears the scoreboard immediately (asynchronous).
- Latency:
  - Handshake in cycle N → rf_write_en_o high in cycle N+1 → register file updated at the end of N+1.
  - busy clears at that same edge, so rsN_busy_o falls in cycle N+2.
- Read-before-write register file: during cycle N+1 a register-file read still returns old data. busy stays 1 through N+1, so decode must not read the value yet.
- Throughput: one write per cycle sustained. A requester held valid under full contention is granted within NUM_REQ cycles.

## Structure
- riscv_core_pkg supplies reg_addr_t, word_t and REG_COUNT. A new constant WB_NUM_REQ=3 is added there, and the top level passes it as NUM_REQ.
- Sub-module rr_arbiter (parameter N; ports: req, grant, ptr update) is reusable for other shared resources. The scoreboard and output register stay in reg_wb_scheduler.
- Non-synthesis SVA:
  - req_ready_o is one-hot-or-zero.
  - No rf_write_en_o with rf_rd_addr_o=0.
  - No issue_valid_i to a busy nonzero rd.
  - A valid held request is never dropped before ready.

## Test plan
- Reset, then a single request from requester 1 (addr 5, data 0xDEADBEEF) → ready[1] in cycle 0. Cycle 1: rf_write_en_o=1, addr 5, data 0xDEADBEEF. Cycle 2: rf_write_en_o=0.
- All three requesters valid continuously for 6 cycles → grants 0,1,2,0,1,2. Each addr/data appears on the register-file port one cycle later, in the same order.
- Requester 2 writes addr 0, data 0x1234 → handshake completes, rf_write_en_o stays 0. The x0 SVA does not fire, and busy is unchanged.
- Issue rd=7 → rs1_busy_o=1 for rs1_addr_i=7 next cycle. Writeback of 7 → busy stays 1 through the rf_write_en_o cycle and reads 0 the cycle after.
- In the cycle rf_write_en_o commits rd=9, issue rd=9 again → busy[9] remains 1 (set wins).
- Drive rst_ni low while a write sits in the output stage and busy[3]=1 → rf_write_en_o and busy clear asynchronously, and ptr returns to 0 (first grant after reset goes to requester 0 under full contention).

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Core-wide types and constants shared by the register-file write-back path.
package riscv_core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);
  localparam int unsigned WB_NUM_REQ = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// ptr moves past the winner whenever update is asserted with a grant.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  input  logic         update
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] win;
  logic             found;

  // Scan ptr, ptr+1, ... modulo N; first valid index wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    win   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[PTR_W'(idx)]) begin
        found               = 1'b1;
        grant[PTR_W'(idx)]  = 1'b1;
        win                 = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update && found) begin
      ptr_d = (32'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration onto the single register-file
// write port, x0 write suppression, and a per-register busy scoreboard.
module reg_wb_scheduler
  import riscv_core_pkg::*;
#(
  parameter int unsigned NUM_REQ = WB_NUM_REQ
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic      [NUM_REQ-1:0]  req_valid_i,
  input  reg_addr_t [NUM_REQ-1:0]  req_addr_i,
  input  word_t     [NUM_REQ-1:0]  req_data_i,
  output logic      [NUM_REQ-1:0]  req_ready_o,
  output logic                     rf_write_en_o,
  output reg_addr_t                rf_rd_addr_o,
  output word_t                    rf_rd_data_o,
  input  logic                     issue_valid_i,
  input  reg_addr_t                issue_rd_i,
  input  reg_addr_t                rs1_addr_i,
  input  reg_addr_t                rs2_addr_i,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o
);

  logic      [NUM_REQ-1:0]   grant;
  logic                      xfer;
  reg_addr_t                 win_addr;
  word_t                     win_data;

  logic                      wr_en_q,   wr_en_d;
  reg_addr_t                 wr_addr_q, wr_addr_d;
  word_t                     wr_data_q, wr_data_d;
  logic      [REG_COUNT-1:0] busy_q,    busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_valid_i),
    .grant  (grant),
    .update (xfer)
  );

  assign req_ready_o = grant;
  assign xfer        = |grant;

  // One-hot select of the winning requester's payload.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = win_addr | req_addr_i[i];
        win_data = win_data | req_data_i[i];
      end
    end
  end

  // Output stage: address/data hold when idle; x0 never raises the enable.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_en_d   = (win_addr != '0);
      wr_addr_d = win_addr;
      wr_data_d = win_data;
    end
  end

  // Clear on commit, then set on issue so a re-issue in the commit cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (issue_valid_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_write_en_o = wr_en_q;
  assign rf_rd_addr_o  = wr_addr_q;
  assign rf_rd_data_o  = wr_data_q;
  assign rs1_busy_o    = busy_q[rs1_addr_i];
  assign rs2_busy_o    = busy_q[rs2_addr_i];

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_no_x0_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_write_en_o |-> (rf_rd_addr_o != '0));

  // Re-issue is allowed only in the cycle the pending write commits.
  a_no_issue_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (issue_valid_i && (issue_rd_i != '0)) |->
      (!busy_q[issue_rd_i] || (rf_write_en_o && (rf_rd_addr_o == issue_rd_i))));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g]) |=>
        (req_valid_i[g] && $stable(req_addr_i[g]) && $stable(req_data_i[g])));
  end
`endif

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Scoreboard bench for reg_wb_scheduler: arbitration order, write port, busy tracking.
module tb_reg_wb_scheduler;
  import riscv_core_pkg::*;

  localparam int unsigned N = WB_NUM_REQ;
  localparam int DEPTH = 8;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic      [N-1:0]   req_valid_i;
  reg_addr_t [N-1:0]   req_addr_i;
  word_t     [N-1:0]   req_data_i;
  logic      [N-1:0]   req_ready_o;
  logic                rf_write_en_o;
  reg_addr_t           rf_rd_addr_o;
  word_t               rf_rd_data_o;
  logic                issue_valid_i;
  reg_addr_t           issue_rd_i;
  reg_addr_t           rs1_addr_i;
  reg_addr_t           rs2_addr_i;
  logic                rs1_busy_o;
  logic                rs2_busy_o;

  reg_wb_scheduler #(.NUM_REQ(N)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .rf_write_en_o (rf_write_en_o),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_rd_data_o  (rf_rd_data_o),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_busy_o    (rs1_busy_o),
    .rs2_busy_o    (rs2_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    word_t     data;
  } wb_t;

  wb_t       exp_q[$];
  reg_addr_t pa [N][DEPTH];
  word_t     pd [N][DEPTH];
  int        ph [N];
  int        pt [N];
  int        mptr;
  int        last_grant;
  int        tests;
  int        fails;

  task automatic model_reset();
    mptr = 0;
    last_grant = -1;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      ph[i] = 0;
      pt[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_data_i    = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic enq(input int i, input reg_addr_t a, input word_t d);
    pa[i][pt[i]] = a;
    pd[i][pt[i]] = d;
    pt[i]++;
  endtask

  // One clock: present requests, check grant vs. round-robin model, then check the write port.
  task automatic cycle();
    int w;
    int idx;
    logic [N-1:0] exp_rdy;
    wb_t e;
    wb_t got;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = (ph[i] < pt[i]);
      if (ph[i] < pt[i]) begin
        req_addr_i[i] = pa[i][ph[i]];
        req_data_i[i] = pd[i][ph[i]];
      end
    end
    #1;
    w = -1;
    for (int off = 0; off < N; off++) begin
      idx = (mptr + off) % N;
      if (w < 0 && req_valid_i[idx]) w = idx;
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    tests++;
    if (req_ready_o !== exp_rdy) begin
      fails++;
      $display("FAIL ready: got %b expected %b", req_ready_o, exp_rdy);
    end
    last_grant = w;
    e = '0;
    if (w >= 0) begin
      e.en   = (pa[w][ph[w]] != '0);
      e.addr = pa[w][ph[w]];
      e.data = pd[w][ph[w]];
      mptr   = (w + 1) % N;
    end
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) begin
      if (req_valid_i[i] && req_ready_o[i]) ph[i]++;
    end
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    got.en = rf_write_en_o;
    got.addr = rf_rd_addr_o;
    got.data = rf_rd_data_o;
    tests++;
    if (got.en !== e.en || (e.en && (got.addr !== e.addr || got.data !== e.data))) begin
      fails++;
      $display("FAIL rf_port: got en=%b addr=%0d data=%h expected en=%b addr=%0d data=%h",
               got.en, got.addr, got.data, e.en, e.addr, e.data);
    end
  endtask

  task automatic test_reset();
    rs1_addr_i = 5'd5;
    rs2_addr_i = 5'd0;
    do_reset();
    tests++;
    if ({rf_write_en_o, rf_rd_addr_o, rf_rd_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_rf: got en=%b addr=%0d data=%h expected all 0",
               rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
    end
    tests++;
    if (req_ready_o !== '0 || rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_misc: got ready=%b rs1=%b rs2=%b expected 0",
               req_ready_o, rs1_busy_o, rs2_busy_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    enq(1, 5'd5, 32'hDEADBEEF);
    cycle();
    tests++;
    if (last_grant != 1) begin
      fails++;
      $display("FAIL single_grant: got %0d expected 1", last_grant);
    end
    tests++;
    if (rf_write_en_o !== 1'b1 || rf_rd_addr_o !== 5'd5 || rf_rd_data_o !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h expected 1/5/deadbeef",
               rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
    end
    cycle();
    tests++;
    if (rf_write_en_o !== 1'b0 || rf_rd_data_o !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_idle: got en=%b data=%h expected 0/deadbeef (held)",
               rf_write_en_o, rf_rd_data_o);
    end
  endtask

  task automatic test_contention();
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        enq(i, reg_addr_t'(10 + 3 * r + i), word_t'(32'hA000_0000 + 32'(16 * r + i)));
      end
    end
    for (int c = 0; c < 6; c++) begin
      cycle();
      tests++;
      if (last_grant != exp_order[c]) begin
        fails++;
        $display("FAIL contention_order[%0d]: got %0d expected %0d", c, last_grant, exp_order[c]);
      end
    end
    cycle();
  endtask

  task automatic test_x0();
    do_reset();
    rs1_addr_i = 5'd0;
    enq(2, 5'd0, 32'h1234);
    cycle();
    tests++;
    if (last_grant != 2 || rf_write_en_o !== 1'b0 || rs1_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL x0_write: got grant=%0d en=%b busy0=%b expected 2/0/0",
               last_grant, rf_write_en_o, rs1_busy_o);
    end
  endtask

  task automatic test_busy();
    do_reset();
    rs1_addr_i    = 5'd7;
    rs2_addr_i    = 5'd8;
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd7;
    cycle();
    issue_valid_i = 1'b0;
    tests++;
    if (rs1_busy_o !== 1'b1 || rs2_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL busy_set: got rs1=%b rs2=%b expected 1/0", rs1_busy_o, rs2_busy_o);
    end
    enq(0, 5'd7, 32'h0000_0777);
    cycle();
    tests++;
    if (rf_write_en_o !== 1'b1 || rs1_busy_o !== 1'b1) begin
      fails++;
      $display("FAIL busy_commit_cycle: got en=%b busy=%b expected 1/1", rf_write_en_o, rs1_busy_o);
    end
    cycle();
    tests++;
    if (rs1_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL busy_clear: got %b expected 0", rs1_busy_o);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    rs1_addr_i    = 5'd9;
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd9;
    cycle();
    issue_valid_i = 1'b0;
    enq(1, 5'd9, 32'h0000_0999);
    cycle();
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd9;
    cycle();
    issue_valid_i = 1'b0;
    tests++;
    if (rs1_busy_o !== 1'b1) begin
      fails++;
      $display("FAIL set_wins: got %b expected 1", rs1_busy_o);
    end
    cycle();
    tests++;
    if (rs1_busy_o !== 1'b1) begin
      fails++;
      $display("FAIL set_wins_hold: got %b expected 1", rs1_busy_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rs1_addr_i    = 5'd3;
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd3;
    cycle();
    issue_valid_i = 1'b0;
    enq(0, 5'd4, 32'h4444);
    enq(1, 5'd3, 32'h3333);
    cycle();
    tests++;
    if (rf_write_en_o !== 1'b1 || rs1_busy_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: got en=%b busy3=%b expected 1/1", rf_write_en_o, rs1_busy_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    tests++;
    if (rf_write_en_o !== 1'b0 || rs1_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL mid_async_clear: got en=%b busy3=%b expected 0/0", rf_write_en_o, rs1_busy_o);
    end
    req_valid_i = '0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) enq(i, reg_addr_t'(20 + i), word_t'(32'hB0 + 32'(i)));
    cycle();
    tests++;
    if (last_grant != 0) begin
      fails++;
      $display("FAIL mid_ptr_reset: got grant %0d expected 0", last_grant);
    end
    cycle();
    cycle();
    cycle();
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_ni        = 1'b0;
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_data_i    = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    rs1_addr_i    = '0;
    rs2_addr_i    = '0;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_busy();
    test_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
